sevenseg_scan_decoder: RTL and testbench

Receive-side counterpart of the board's hex-to-segment encoder: observes a time-multiplexed, active-low seven-segment bus and reconstructs the hex value shown on each digit. Each observed pattern must persist for a programmable number of samples before it is committed, which filters scan glitches. The block sits beside the display driver in the water-reminder top level and feeds the self-check/readback logic. It flags blank digits and patterns outside the 16-code set.

---
 rtl/sevenseg_scan_decoder_if.sv | 40 ++++
 rtl/sevenseg_scan_decoder.sv | 183 ++++++++++++++++++
 tb/tb_sevenseg_scan_decoder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_decoder_if.sv
// sevenseg_scan_decoder_if
//   Bundles the observed seven-segment scan bus and the decoded readback
//   outputs of sevenseg_scan_decoder.
//   master : drives sample_en/digit_sel/segments, observes decoded state
//   slave  : the decoder itself
// Signals:
//   sample_en    segments/digit_sel valid this cycle
//   digit_sel    digit currently driven on the bus
//   segments     active-low pattern, bit6=g .. bit0=a
//   hex_out      committed nibble per digit, digit i at [4i+3:4i]
//   digit_valid  digit holds one of the 16 legal codes
//   digit_blank  digit committed as all-off
//   update       one-cycle pulse when a digit's committed state changes
//   update_idx   digit that changed on the last update
//   illegal_seen sticky flag, an illegal pattern was committed
interface sevenseg_scan_decoder_if #(
  parameter int DIGITS = 6
);
  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                  sample_en;
  logic [SEL_W-1:0]      digit_sel;
  logic [6:0]            segments;
  logic [4*DIGITS-1:0]   hex_out;
  logic [DIGITS-1:0]     digit_valid;
  logic [DIGITS-1:0]     digit_blank;
  logic                  update;
  logic [SEL_W-1:0]      update_idx;
  logic                  illegal_seen;

  modport master (
    output sample_en, digit_sel, segments,
    input  hex_out, digit_valid, digit_blank, update, update_idx, illegal_seen
  );

  modport slave (
    input  sample_en, digit_sel, segments,
    output hex_out, digit_valid, digit_blank, update, update_idx, illegal_seen
  );
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder
//   Observes a time-multiplexed active-low seven-segment bus and rebuilds
//   the hex value shown on each digit. A pattern must be seen on the same
//   digit STABLE_SAMPLES times in a row (counting only that digit's own
//   samples) before it is committed, which filters scan glitches.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    sevenseg_scan_decoder_if.slave (scan inputs, decoded outputs)
module sevenseg_scan_decoder #(
  parameter int DIGITS         = 6,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  sevenseg_scan_decoder_if.slave  bus
);

  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] STAB_C = CNT_W'(STABLE_SAMPLES);

  // Decode an active-low {g..a} pattern into {legal, blank, nibble}.
  function automatic logic [5:0] decode_seg(input logic [6:0] seg);
    logic [5:0] r;
    case (seg)
      7'h40:   r = {1'b1, 1'b0, 4'h0};
      7'h79:   r = {1'b1, 1'b0, 4'h1};
      7'h24:   r = {1'b1, 1'b0, 4'h2};
      7'h30:   r = {1'b1, 1'b0, 4'h3};
      7'h19:   r = {1'b1, 1'b0, 4'h4};
      7'h12:   r = {1'b1, 1'b0, 4'h5};
      7'h02:   r = {1'b1, 1'b0, 4'h6};
      7'h78:   r = {1'b1, 1'b0, 4'h7};
      7'h00:   r = {1'b1, 1'b0, 4'h8};
      7'h18:   r = {1'b1, 1'b0, 4'h9};
      7'h08:   r = {1'b1, 1'b0, 4'hA};
      7'h03:   r = {1'b1, 1'b0, 4'hB};
      7'h27:   r = {1'b1, 1'b0, 4'hC};
      7'h21:   r = {1'b1, 1'b0, 4'hD};
      7'h06:   r = {1'b1, 1'b0, 4'hE};
      7'h0E:   r = {1'b1, 1'b0, 4'hF};
      7'h7F:   r = {1'b0, 1'b1, 4'h0};
      default: r = {1'b0, 1'b0, 4'h0};
    endcase
    return r;
  endfunction

  logic [6:0]       candidate_r [DIGITS];
  logic [CNT_W-1:0] count_r     [DIGITS];
  logic [3:0]       nib_r       [DIGITS];
  logic [DIGITS-1:0] valid_r;
  logic [DIGITS-1:0] blank_r;
  logic             update_r;
  logic [SEL_W-1:0] update_idx_r;
  logic             illegal_r;

  logic [DIGITS-1:0] sel_match_s;
  logic             hit_s;
  logic [6:0]       cur_cand_s;
  logic [CNT_W-1:0] cur_cnt_s;
  logic [3:0]       cur_nib_s;
  logic             cur_valid_s;
  logic             cur_blank_s;
  logic [6:0]       next_cand_s;
  logic [CNT_W-1:0] next_cnt_s;
  logic             cand_changed_s;
  logic [5:0]       dec_s;
  logic             commit_s;
  logic [3:0]       new_nib_s;
  logic             new_valid_s;
  logic             new_blank_s;
  logic             illegal_s;
  logic             change_s;

  // Select the addressed digit's state; out-of-range selects match nothing.
  always_comb begin
    sel_match_s = '0;
    hit_s       = 1'b0;
    cur_cand_s  = 7'h7F;
    cur_cnt_s   = '0;
    cur_nib_s   = 4'h0;
    cur_valid_s = 1'b0;
    cur_blank_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.sample_en && (bus.digit_sel == SEL_W'(i))) begin
        sel_match_s[i] = 1'b1;
        hit_s          = 1'b1;
        cur_cand_s     = candidate_r[i];
        cur_cnt_s      = count_r[i];
        cur_nib_s      = nib_r[i];
        cur_valid_s    = valid_r[i];
        cur_blank_s    = blank_r[i];
      end else begin
        sel_match_s[i] = 1'b0;
      end
    end
  end

  // Stability counting, commit detection and the resulting digit state.
  always_comb begin
    dec_s = decode_seg(bus.segments);
    if (bus.segments == cur_cand_s) begin
      next_cand_s    = cur_cand_s;
      cand_changed_s = 1'b0;
      next_cnt_s     = (cur_cnt_s == STAB_C) ? cur_cnt_s : cur_cnt_s + CNT_W'(1);
    end else begin
      next_cand_s    = bus.segments;
      cand_changed_s = 1'b1;
      next_cnt_s     = CNT_W'(1);
    end

    // With a threshold of 1 the count is already saturated, so a changed
    // candidate is the only way a new pattern can commit.
    commit_s = hit_s && (((next_cnt_s == STAB_C) && (cur_cnt_s != STAB_C)) ||
                         ((STABLE_SAMPLES == 1) && cand_changed_s));

    // On commit the candidate always equals the current segments, so the
    // decode of the bus value is the decode of the committed pattern.
    if (dec_s[5]) begin
      new_valid_s = 1'b1;
      new_blank_s = 1'b0;
      new_nib_s   = dec_s[3:0];
    end else if (dec_s[4]) begin
      new_valid_s = 1'b0;
      new_blank_s = 1'b1;
      new_nib_s   = cur_nib_s;
    end else begin
      new_valid_s = 1'b0;
      new_blank_s = 1'b0;
      new_nib_s   = cur_nib_s;
    end
    illegal_s = ~dec_s[5] & ~dec_s[4];
    change_s  = commit_s &&
                ({new_valid_s, new_blank_s, new_nib_s} != {cur_valid_s, cur_blank_s, cur_nib_s});
  end

  // Per-digit state, committed outputs, update pulse and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DIGITS; i++) begin
        candidate_r[i] <= 7'h7F;
        count_r[i]     <= '0;
        nib_r[i]       <= 4'h0;
      end
      valid_r      <= '0;
      blank_r      <= '1;
      update_r     <= 1'b0;
      update_idx_r <= '0;
      illegal_r    <= 1'b0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (sel_match_s[i]) begin
          candidate_r[i] <= next_cand_s;
          count_r[i]     <= next_cnt_s;
        end
        if (sel_match_s[i] && commit_s) begin
          nib_r[i]   <= new_nib_s;
          valid_r[i] <= new_valid_s;
          blank_r[i] <= new_blank_s;
        end
      end
      update_r <= change_s;
      if (change_s) begin
        update_idx_r <= bus.digit_sel;
      end
      if (commit_s && illegal_s) begin
        illegal_r <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_pack
    assign bus.hex_out[4*g +: 4] = nib_r[g];
  end

  assign bus.digit_valid  = valid_r;
  assign bus.digit_blank  = blank_r;
  assign bus.update       = update_r;
  assign bus.update_idx   = update_idx_r;
  assign bus.illegal_seen = illegal_r;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// tb_sevenseg_scan_decoder
//   Directed self-checking bench for sevenseg_scan_decoder (DIGITS=6,
//   STABLE_SAMPLES=4). Inputs change on the falling edge; outputs are
//   checked 1 time unit after the rising edge that consumed the sample.
module tb_sevenseg_scan_decoder;

  localparam int DIGITS = 6;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sevenseg_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

  sevenseg_scan_decoder #(.DIGITS(DIGITS), .STABLE_SAMPLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic do_sample(input logic [2:0] sel, input logic [6:0] seg);
    @(negedge clk);
    bus.sample_en = 1'b1;
    bus.digit_sel = sel;
    bus.segments  = seg;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.sample_en = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    bus.sample_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.hex_out !== 24'h0) begin errors++; $display("FAIL reset_hex: got %h expected %h", bus.hex_out, 24'h0); end
    checks++; if (bus.digit_valid !== 6'h00) begin errors++; $display("FAIL reset_valid: got %h expected %h", bus.digit_valid, 6'h00); end
    checks++; if (bus.digit_blank !== 6'h3F) begin errors++; $display("FAIL reset_blank: got %h expected %h", bus.digit_blank, 6'h3F); end
    checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL reset_update: got %b expected %b", bus.update, 1'b0); end
    checks++; if (bus.update_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d expected %0d", bus.update_idx, 0); end
    checks++; if (bus.illegal_seen !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected %b", bus.illegal_seen, 1'b0); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_commit;
    for (int k = 0; k < 4; k++) begin
      do_sample(3'd2, 7'h24);
      if (k < 3) begin
        checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL single_early_update k=%0d: got %b expected %b", k, bus.update, 1'b0); end
      end
    end
    checks++; if (bus.hex_out[11:8] !== 4'h2) begin errors++; $display("FAIL single_hex: got %h expected %h", bus.hex_out[11:8], 4'h2); end
    checks++; if (bus.digit_valid[2] !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected %b", bus.digit_valid[2], 1'b1); end
    checks++; if (bus.digit_blank[2] !== 1'b0) begin errors++; $display("FAIL single_blank: got %b expected %b", bus.digit_blank[2], 1'b0); end
    checks++; if (bus.update !== 1'b1) begin errors++; $display("FAIL single_update: got %b expected %b", bus.update, 1'b1); end
    checks++; if (bus.update_idx !== 3'd2) begin errors++; $display("FAIL single_idx: got %0d expected %0d", bus.update_idx, 2); end
    idle(1);
    checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b expected %b", bus.update, 1'b0); end
  endtask

  task automatic test_glitch_filter;
    logic [6:0] seq [8];
    logic [7:0] exp_upd;
    int pulses;
    seq = '{7'h12, 7'h12, 7'h12, 7'h02, 7'h02, 7'h02, 7'h02, 7'h02};
    exp_upd = 8'b0100_0000;  // only the 4th consecutive 7'h02 commits
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      do_sample(3'd0, seq[k]);
      if (bus.update === 1'b1) pulses++;
      checks++; if (bus.update !== exp_upd[k]) begin errors++; $display("FAIL glitch_update k=%0d: got %b expected %b", k, bus.update, exp_upd[k]); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL glitch_pulses: got %0d expected %0d", pulses, 1); end
    checks++; if (bus.hex_out[3:0] !== 4'h6) begin errors++; $display("FAIL glitch_hex: got %h expected %h", bus.hex_out[3:0], 4'h6); end
    checks++; if (bus.digit_valid[0] !== 1'b1) begin errors++; $display("FAIL glitch_valid: got %b expected %b", bus.digit_valid[0], 1'b1); end
    idle(1);
  endtask

  task automatic test_back_to_back;
    logic [6:0] seg_tab [6];
    seg_tab = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 6; i++) begin
        do_sample(3'(i), seg_tab[i]);
        checks++; if (bus.update !== (r == 3)) begin errors++; $display("FAIL b2b_update r=%0d i=%0d: got %b expected %b", r, i, bus.update, (r == 3)); end
        if (r == 3) begin
          checks++; if (bus.update_idx !== 3'(i)) begin errors++; $display("FAIL b2b_idx i=%0d: got %0d expected %0d", i, bus.update_idx, i); end
        end
      end
    end
    checks++; if (bus.hex_out !== 24'h654321) begin errors++; $display("FAIL b2b_hex: got %h expected %h", bus.hex_out, 24'h654321); end
    checks++; if (bus.digit_valid !== 6'h3F) begin errors++; $display("FAIL b2b_valid: got %h expected %h", bus.digit_valid, 6'h3F); end
    checks++; if (bus.digit_blank !== 6'h00) begin errors++; $display("FAIL b2b_blank: got %h expected %h", bus.digit_blank, 6'h00); end
    idle(1);
  endtask

  task automatic test_illegal;
    for (int k = 0; k < 4; k++) do_sample(3'd1, 7'h55);
    checks++; if (bus.update !== 1'b1) begin errors++; $display("FAIL illegal_update: got %b expected %b", bus.update, 1'b1); end
    checks++; if (bus.digit_valid[1] !== 1'b0) begin errors++; $display("FAIL illegal_valid: got %b expected %b", bus.digit_valid[1], 1'b0); end
    checks++; if (bus.digit_blank[1] !== 1'b0) begin errors++; $display("FAIL illegal_blank: got %b expected %b", bus.digit_blank[1], 1'b0); end
    checks++; if (bus.illegal_seen !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b expected %b", bus.illegal_seen, 1'b1); end
    checks++; if (bus.hex_out[7:4] !== 4'h2) begin errors++; $display("FAIL illegal_hex_kept: got %h expected %h", bus.hex_out[7:4], 4'h2); end
    for (int k = 0; k < 4; k++) do_sample(3'd1, 7'h40);
    checks++; if (bus.digit_valid[1] !== 1'b1) begin errors++; $display("FAIL illegal_recover_valid: got %b expected %b", bus.digit_valid[1], 1'b1); end
    checks++; if (bus.hex_out[7:4] !== 4'h0) begin errors++; $display("FAIL illegal_recover_hex: got %h expected %h", bus.hex_out[7:4], 4'h0); end
    checks++; if (bus.illegal_seen !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b expected %b", bus.illegal_seen, 1'b1); end
    idle(1);
  endtask

  task automatic test_blank_and_ignore;
    for (int k = 0; k < 4; k++) do_sample(3'd3, 7'h78);
    checks++; if (bus.hex_out[15:12] !== 4'h7) begin errors++; $display("FAIL blank_pre_hex: got %h expected %h", bus.hex_out[15:12], 4'h7); end
    checks++; if (bus.update !== 1'b1) begin errors++; $display("FAIL blank_pre_update: got %b expected %b", bus.update, 1'b1); end
    for (int k = 0; k < 4; k++) do_sample(3'd3, 7'h7F);
    checks++; if (bus.digit_blank[3] !== 1'b1) begin errors++; $display("FAIL blank_flag: got %b expected %b", bus.digit_blank[3], 1'b1); end
    checks++; if (bus.digit_valid[3] !== 1'b0) begin errors++; $display("FAIL blank_valid: got %b expected %b", bus.digit_valid[3], 1'b0); end
    checks++; if (bus.hex_out[15:12] !== 4'h7) begin errors++; $display("FAIL blank_hex_kept: got %h expected %h", bus.hex_out[15:12], 4'h7); end
    checks++; if (bus.update !== 1'b1) begin errors++; $display("FAIL blank_update: got %b expected %b", bus.update, 1'b1); end
    for (int k = 0; k < 8; k++) begin
      do_sample((k % 2 == 0) ? 3'd6 : 3'd7, 7'h00);
      checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL ignore_update k=%0d: got %b expected %b", k, bus.update, 1'b0); end
    end
    checks++; if (bus.hex_out !== 24'h657301) begin errors++; $display("FAIL ignore_hex: got %h expected %h", bus.hex_out, 24'h657301); end
    checks++; if (bus.digit_valid !== 6'h37) begin errors++; $display("FAIL ignore_valid: got %h expected %h", bus.digit_valid, 6'h37); end
    checks++; if (bus.digit_blank !== 6'h08) begin errors++; $display("FAIL ignore_blank: got %h expected %h", bus.digit_blank, 6'h08); end
    idle(1);
  endtask

  task automatic test_reset_mid_stream;
    for (int k = 0; k < 3; k++) do_sample(3'd4, 7'h19);
    @(negedge clk);
    reset = 1'b1;
    bus.sample_en = 1'b1;
    bus.digit_sel = 3'd4;
    bus.segments  = 7'h19;
    @(posedge clk);
    #1;
    checks++; if (bus.hex_out !== 24'h0) begin errors++; $display("FAIL midrst_hex: got %h expected %h", bus.hex_out, 24'h0); end
    checks++; if (bus.digit_valid !== 6'h00) begin errors++; $display("FAIL midrst_valid: got %h expected %h", bus.digit_valid, 6'h00); end
    checks++; if (bus.digit_blank !== 6'h3F) begin errors++; $display("FAIL midrst_blank: got %h expected %h", bus.digit_blank, 6'h3F); end
    checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL midrst_update: got %b expected %b", bus.update, 1'b0); end
    checks++; if (bus.illegal_seen !== 1'b0) begin errors++; $display("FAIL midrst_illegal: got %b expected %b", bus.illegal_seen, 1'b0); end
    @(negedge clk);
    reset = 1'b0;
    bus.sample_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_sample(3'd4, 7'h19);
      if (k < 3) begin
        checks++; if (bus.update !== 1'b0 || bus.digit_valid[4] !== 1'b0) begin errors++; $display("FAIL midrst_early k=%0d: got update=%b valid=%b expected update=0 valid=0", k, bus.update, bus.digit_valid[4]); end
      end
    end
    checks++; if (bus.update !== 1'b1) begin errors++; $display("FAIL midrst_commit_update: got %b expected %b", bus.update, 1'b1); end
    checks++; if (bus.update_idx !== 3'd4) begin errors++; $display("FAIL midrst_commit_idx: got %0d expected %0d", bus.update_idx, 4); end
    checks++; if (bus.hex_out[19:16] !== 4'h4) begin errors++; $display("FAIL midrst_commit_hex: got %h expected %h", bus.hex_out[19:16], 4'h4); end
    idle(1);
  endtask

  task automatic test_no_update_recommit;
    for (int k = 0; k < 4; k++) begin
      do_sample(3'd5, 7'h7F);
      checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL recommit_blank_update k=%0d: got %b expected %b", k, bus.update, 1'b0); end
    end
    checks++; if (bus.digit_blank !== 6'h2F) begin errors++; $display("FAIL recommit_blank: got %h expected %h", bus.digit_blank, 6'h2F); end
    do_sample(3'd4, 7'h12);
    for (int k = 0; k < 4; k++) begin
      do_sample(3'd4, 7'h19);
      checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL recommit_same_update k=%0d: got %b expected %b", k, bus.update, 1'b0); end
    end
    checks++; if (bus.hex_out[19:16] !== 4'h4 || bus.digit_valid[4] !== 1'b1) begin errors++; $display("FAIL recommit_state: got hex=%h valid=%b expected hex=4 valid=1", bus.hex_out[19:16], bus.digit_valid[4]); end
    idle(1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.sample_en = 1'b0;
    bus.digit_sel = 3'd0;
    bus.segments  = 7'h7F;
    test_reset();
    test_single_commit();
    test_glitch_filter();
    test_back_to_back();
    test_illegal();
    test_blank_and_ignore();
    test_reset_mid_stream();
    test_no_update_recommit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
